// File: rtl/branch_sequencer.sv
// Conditional-branch sub-sequencer (brzr/brnz/brpl/brmi).
// Loads the CON flip-flop, reads the result back, forms PC + sign-extended C
// and loads PC only for a taken branch. Hands back to the main sequencer with
// a one-cycle done pulse and keeps a running count of taken branches.
module branch_sequencer #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned SKIP_NOT_TAKEN = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con,
  output logic             gra,
  output logic             rout,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StEval   = 3'd1,
    StCheck  = 3'd2,
    StAddr1  = 3'd3,
    StAddr2  = 3'd4,
    StLoadPc = 3'd5,
    StFin    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic             taken_q;
  logic [CNT_W-1:0] count_q;

  // Condition code and Ra are decoded by the CON flip-flop and register file.
  logic unused_ir;
  assign unused_ir = ^ir;

  // State register; clear aborts any sequence immediately.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch outcome and statistics, sampled only in the CHECK wait cycle.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      taken_q <= 1'b0;
      count_q <= '0;
    end else if (state_q == StCheck) begin
      taken_q <= con;
      if (con) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic and Moore strobe decode.
  always_comb begin
    state_d  = state_q;
    gra      = 1'b0;
    rout     = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StEval;
      end
      StEval: begin
        gra     = 1'b1;
        rout    = 1'b1;
        con_in  = 1'b1;
        busy    = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        busy = 1'b1;
        if (!con && (SKIP_NOT_TAKEN != 0)) state_d = StFin;
        else                               state_d = StAddr1;
      end
      StAddr1: begin
        pc_out  = 1'b1;
        y_in    = 1'b1;
        busy    = 1'b1;
        state_d = StAddr2;
      end
      StAddr2: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
        busy    = 1'b1;
        state_d = StLoadPc;
      end
      StLoadPc: begin
        zlow_out = 1'b1;
        busy     = 1'b1;
        // Registered outcome, so con glitches after CHECK cannot load PC.
        pc_in    = taken_q;
        state_d  = StFin;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign taken       = taken_q;
  assign taken_count = count_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: one skipping instance (16-bit counter) and one
// full-path instance (4-bit counter so wraparound is reachable quickly).
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = 32'h0818_1234;
  logic        s0 = 1'b0, c0 = 1'b0, s1 = 1'b0, c1 = 1'b0;

  logic gra0, rout0, con_in0, pc_out0, y_in0, c_out0, alu_add0, z_in0, zlow_out0, pc_in0;
  logic busy0, done0, taken0;
  logic [15:0] count0;
  logic gra1, rout1, con_in1, pc_out1, y_in1, c_out1, alu_add1, z_in1, zlow_out1, pc_in1;
  logic busy1, done1, taken1;
  logic [3:0] count1;

  branch_sequencer #(.CNT_W(16), .SKIP_NOT_TAKEN(1)) dut_s (
    .clk(clk), .clear(clear), .start(s0), .ir(ir), .con(c0),
    .gra(gra0), .rout(rout0), .con_in(con_in0), .pc_out(pc_out0), .y_in(y_in0),
    .c_out(c_out0), .alu_add(alu_add0), .z_in(z_in0), .zlow_out(zlow_out0),
    .pc_in(pc_in0), .busy(busy0), .done(done0), .taken(taken0), .taken_count(count0)
  );

  branch_sequencer #(.CNT_W(4), .SKIP_NOT_TAKEN(0)) dut_f (
    .clk(clk), .clear(clear), .start(s1), .ir(ir), .con(c1),
    .gra(gra1), .rout(rout1), .con_in(con_in1), .pc_out(pc_out1), .y_in(y_in1),
    .c_out(c_out1), .alu_add(alu_add1), .z_in(z_in1), .zlow_out(zlow_out1),
    .pc_in(pc_in1), .busy(busy1), .done(done1), .taken(taken1), .taken_count(count1)
  );

  // Strobe vector: gra rout con_in pc_out y_in c_out alu_add z_in zlow_out pc_in busy done
  logic [11:0] o0, o1;
  assign o0 = {gra0, rout0, con_in0, pc_out0, y_in0, c_out0, alu_add0, z_in0, zlow_out0,
               pc_in0, busy0, done0};
  assign o1 = {gra1, rout1, con_in1, pc_out1, y_in1, c_out1, alu_add1, z_in1, zlow_out1,
               pc_in1, busy1, done1};

  localparam logic [11:0] V_IDLE = 12'h000;
  localparam logic [11:0] V_EVAL = 12'hE02;
  localparam logic [11:0] V_CHK  = 12'h002;
  localparam logic [11:0] V_A1   = 12'h182;
  localparam logic [11:0] V_A2   = 12'h072;
  localparam logic [11:0] V_LDN  = 12'h00A;
  localparam logic [11:0] V_LDT  = 12'h00E;
  localparam logic [11:0] V_FIN  = 12'h001;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b1;
    s0 = 1'b0; s1 = 1'b0; c0 = 1'b0; c1 = 1'b0;
    @(negedge clk);
    check("reset_strobes_s", {20'd0, o0}, {20'd0, V_IDLE});
    check("reset_strobes_f", {20'd0, o1}, {20'd0, V_IDLE});
    clear = 1'b0;
  endtask

  // Run one branch with con held constant; checks start-to-done latency.
  task automatic run_branch(input int which, input bit conval, input int exp_lat);
    int k;
    bit seen;
    if (which == 0) begin s0 = 1'b1; c0 = conval; end
    else            begin s1 = 1'b1; c1 = conval; end
    seen = 1'b0;
    k = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      s0 = 1'b0; s1 = 1'b0;
      seen = (which == 0) ? done0 : done1;
    end
    check("branch_latency", k, seen ? exp_lat : -1);
    @(negedge clk);
  endtask

  // Behavioural reference: position = cycles since accepted start, length = 6 or 3.
  int  m_pos[2], m_len[2], m_cnt[2];
  bit  m_tkn[2];
  int  m_mask[2] = '{32'hFFFF, 32'hF};
  bit  m_skip[2] = '{1'b1, 1'b0};

  function automatic logic [11:0] expect_vec(input int pos, input int len, input bit tkn);
    if (pos == 0)   return V_IDLE;
    if (pos == len) return V_FIN;
    case (pos)
      1:       return V_EVAL;
      2:       return V_CHK;
      3:       return V_A1;
      4:       return V_A2;
      default: return tkn ? V_LDT : V_LDN;
    endcase
  endfunction

  task automatic model_step(input int i, input bit st, input bit cv);
    if (m_pos[i] == 2) begin
      m_tkn[i] = cv;
      if (cv) m_cnt[i] = (m_cnt[i] + 1) & m_mask[i];
      m_len[i] = (cv || !m_skip[i]) ? 6 : 3;
    end
    if (m_pos[i] == 0)             m_pos[i] = st ? 1 : 0;
    else if (m_pos[i] == m_len[i]) m_pos[i] = 0;
    else                           m_pos[i] = m_pos[i] + 1;
  endtask

  typedef struct {
    bit          start;
    bit          con;
    logic [11:0] exp;
    bit          exp_taken;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Taken branch with start hammered throughout, then a skipped not-taken one.
    tbl[0]  = '{1'b1, 1'b0, V_EVAL, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, V_CHK,  1'b0};
    tbl[2]  = '{1'b1, 1'b1, V_A1,   1'b1};
    tbl[3]  = '{1'b0, 1'b0, V_A2,   1'b1};
    tbl[4]  = '{1'b1, 1'b0, V_LDT,  1'b1};
    tbl[5]  = '{1'b1, 1'b1, V_FIN,  1'b1};
    tbl[6]  = '{1'b1, 1'b1, V_IDLE, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, V_EVAL, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, V_CHK,  1'b1};
    tbl[9]  = '{1'b0, 1'b0, V_FIN,  1'b0};
    tbl[10] = '{1'b0, 1'b0, V_IDLE, 1'b0};

    do_reset();
    check("reset_count", {16'd0, count0}, 32'd0);
    check("reset_taken", {31'd0, taken0}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      s0 = tbl[i].start;
      c0 = tbl[i].con;
      @(negedge clk);
      check($sformatf("tbl_strobes[%0d]", i), {20'd0, o0}, {20'd0, tbl[i].exp});
      check($sformatf("tbl_taken[%0d]", i), {31'd0, taken0}, {31'd0, tbl[i].exp_taken});
    end
    check("tbl_count", {16'd0, count0}, 32'd1);

    // Reset while in ADDR2 on the skipping instance.
    s0 = 1'b1; c0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_addr2", {20'd0, o0}, {20'd0, V_A2});
    #2 clear = 1'b1;
    #1;
    check("midreset_strobes", {20'd0, o0}, {20'd0, V_IDLE});
    check("midreset_count", {16'd0, count0}, 32'd0);
    check("midreset_taken", {31'd0, taken0}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    run_branch(0, 1'b1, 6);
    check("post_reset_count", {16'd0, count0}, 32'd1);
    run_branch(0, 1'b0, 3);
    check("skip_count_kept", {16'd0, count0}, 32'd1);
    check("skip_taken", {31'd0, taken0}, 32'd0);

    // Counter wraparound on the 4-bit instance.
    for (int i = 0; i < 15; i++) run_branch(1, 1'b1, 6);
    check("count_all_ones", {28'd0, count1}, 32'd15);
    run_branch(1, 1'b1, 6);
    check("count_wrap", {28'd0, count1}, 32'd0);

    // Full path, not taken, con flips high after CHECK: pc_in must stay low.
    s1 = 1'b1; c1 = 1'b0;
    @(negedge clk); s1 = 1'b0;
    @(negedge clk);
    @(negedge clk); c1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("late_con_loadpc", {20'd0, o1}, {20'd0, V_LDN});
    @(negedge clk);
    check("late_con_fin", {20'd0, o1}, {20'd0, V_FIN});
    check("late_con_taken", {31'd0, taken1}, 32'd0);
    check("late_con_count", {28'd0, count1}, 32'd0);
    c1 = 1'b0;

    // Randomised run of both instances against the reference model.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_len[i] = 6; m_cnt[i] = 0; m_tkn[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit st0, cv0, st1, cv1;
      check("rnd_strobes_s", {20'd0, o0}, {20'd0, expect_vec(m_pos[0], m_len[0], m_tkn[0])});
      check("rnd_strobes_f", {20'd0, o1}, {20'd0, expect_vec(m_pos[1], m_len[1], m_tkn[1])});
      check("rnd_taken_s", {31'd0, taken0}, {31'd0, m_tkn[0]});
      check("rnd_taken_f", {31'd0, taken1}, {31'd0, m_tkn[1]});
      check("rnd_count_s", {16'd0, count0}, m_cnt[0]);
      check("rnd_count_f", {28'd0, count1}, m_cnt[1]);
      check("rnd_bus_excl", {31'd0, ($countones({rout0, pc_out0, c_out0, zlow_out0}) > 1)},
            32'd0);
      st0 = ($urandom_range(0, 2) == 0);
      st1 = ($urandom_range(0, 2) == 0);
      cv0 = $urandom_range(0, 1) == 1;
      cv1 = $urandom_range(0, 1) == 1;
      s0 = st0; c0 = cv0; s1 = st1; c1 = cv1;
      model_step(0, st0, cv0);
      model_step(1, st1, cv1);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Control-unit sub-FSM that executes the conditional-branch instructions (brzr, brnz, brpl, brmi).
- Drives the datapath strobes that load the CON flip-flop and then reads the CON result back.
- Computes PC + sign-extended C and loads PC only when CON = 1.
- Sits beside the main control sequencer. The main sequencer hands over control after instruction fetch/decode, and the block hands back with a done pulse.

Parameters:
- CNT_W, 16, width of the taken-branch statistics counter.
- SKIP_NOT_TAKEN, 1, if 1 the block ends the sequence right after the CON read when the branch is not taken; if 0 it always runs the address steps and only suppresses PCin.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse from the main sequencer; IR holds a decoded branch.
- ir  input  32  instruction register; ir[20:19] is the condition code (used by the CON flip-flop), ir[26:23] is Ra.
- con  input  1  CON flip-flop output Q.
- gra  output  1  select the Ra field for register read.
- rout  output  1  selected register drives the bus.
- con_in  output  1  CON flip-flop load enable.
- pc_out  output  1  PC drives the bus.
- y_in  output  1  Y register load.
- c_out  output  1  sign-extended C (ir[18:0]) drives the bus.
- alu_add  output  1  ALU operation select = ADD.
- z_in  output  1  Z register load.
- zlow_out  output  1  Z[31:0] drives the bus.
- pc_in  output  1  PC load.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.
- taken  output  1  registered result of the last branch.
- taken_count  output  CNT_W  number of taken branches since reset.

Behaviour:
- Reset (clear = 1, asynchronous):
  - State goes to IDLE.
  - All strobes = 0, busy = 0, done = 0, taken = 0, taken_count = 0.
  - Reset mid-sequence aborts immediately; no partial pc_in is ever issued after clear rises.
- All strobes are Moore outputs decoded from the registered state. Exactly the strobes listed per state are 1; all others are 0.
- IDLE:
  - Outputs: busy = 0.
  - If start = 1, go to EVAL.
- EVAL:
  - Outputs: gra, rout, con_in, busy.
  - The CON flip-flop captures its condition on this edge.
  - Next state: CHECK.
- CHECK:
  - Outputs: busy only. This is a wait cycle so that con reflects the EVAL load.
  - Register taken <= con.
  - If con = 1, increment taken_count. It wraps modulo 2^CNT_W, from all-ones to 0.
  - Next state: if con = 0 and SKIP_NOT_TAKEN = 1, go to FIN; else go to ADDR1.
- ADDR1:
  - Outputs: pc_out, y_in, busy.
  - Next state: ADDR2.
- ADDR2:
  - Outputs: c_out, alu_add, z_in, busy.
  - Next state: LOADPC.
- LOADPC:
  - Outputs: zlow_out, busy, and pc_in = taken (registered in CHECK, not the live con).
  - Next state: FIN.
- FIN:
  - Outputs: done = 1, busy = 0.
  - Next state: IDLE.
- start while busy = 1, or in FIN, is ignored; it is neither queued nor restarted.
- Changes on con outside CHECK have no effect.
- Latency from start to done:
  - 6 cycles when the full path runs.
  - 3 cycles when SKIP_NOT_TAKEN = 1 and the branch is not taken.
- No two bus-driving strobes (rout, pc_out, c_out, zlow_out) are ever 1 in the same cycle.
- An undefined state encoding recovers to IDLE with all outputs 0.

Test Plan:
- Reset while in ADDR2 → same cycle: all strobes = 0, busy = 0; next start gives a normal sequence; taken_count unchanged from before the reset except cleared to 0.
- SKIP_NOT_TAKEN = 1, start with con = 1 at CHECK → strobes per cycle EVAL(gra, rout, con_in), CHECK, ADDR1(pc_out, y_in), ADDR2(c_out, alu_add, z_in), LOADPC(zlow_out, pc_in); done 6 cycles after start; taken = 1; taken_count 0 → 1.
- SKIP_NOT_TAKEN = 1, con = 0 at CHECK → EVAL, CHECK, FIN; done 3 cycles after start; pc_in never asserted; taken = 0; taken_count unchanged.
- SKIP_NOT_TAKEN = 0, con = 0 → full 6-cycle sequence with pc_in = 0 in LOADPC; then toggle con to 1 during ADDR1 → pc_in still 0.
- start pulsed every cycle during a sequence → exactly one done per accepted start; no restart.
- Preload taken_count to 0xFFFF by 65535 taken branches (or force), then one more taken branch → taken_count = 0x0000.
